// File: rtl/mac_pkg.sv
// Shared definitions for the MAC lane array: widths, mode encodings and
// saturation helpers used by every lane.
package mac_pkg;

  localparam int unsigned DEF_LANES = 16;
  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned DEF_ACCW  = 24;
  localparam int unsigned SHW       = 5;
  localparam int unsigned SAT_W     = 64;

  localparam logic MODE_INT8  = 1'b0;
  localparam logic MODE_SIMD4 = 1'b1;

  typedef logic signed [SAT_W-1:0] wide_t;

  localparam wide_t DW_MAX = wide_t'(127);
  localparam wide_t DW_MIN = wide_t'(-128);

  // Clamp a wide signed value into an accw-bit two's complement range.
  function automatic wide_t sat_acc(input wide_t x, input int unsigned accw);
    wide_t hi;
    wide_t lo;
    hi = (SAT_W'(1) << (accw - 1)) - SAT_W'(1);
    lo = ~hi;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Clamp a wide signed value into the signed result byte range.
  function automatic logic signed [7:0] sat_dw(input wide_t x);
    if (x > DW_MAX) return 8'sh7f;
    if (x < DW_MIN) return 8'sh80;
    return x[7:0];
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One signed MAC lane: product generation, S1 product register, saturating
// accumulator with sticky overflow, and the requantised output byte.
module mac_lane
  import mac_pkg::*;
#(
  parameter int unsigned DW   = DEF_DW,
  parameter int unsigned ACCW = DEF_ACCW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           cap_en,
  input  logic           acc_en,
  input  logic           close_en,
  input  logic           sel,
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  w,
  input  logic [SHW-1:0] shift,
  output logic [DW-1:0]  out_byte,
  output logic           out_ovf
);

  localparam int unsigned PW = 2 * DW;

  logic signed [PW-1:0]   prod_c;
  logic signed [PW-1:0]   lo_a_c, lo_w_c, hi_a_c, hi_w_c;
  logic signed [PW-1:0]   s1_prod;
  logic signed [ACCW-1:0] acc;
  logic                   ovf;
  wide_t                  sum_c;
  wide_t                  sat_c;
  logic                   new_ovf_c;

  // Per-beat product: full int8 multiply or a two-term signed nibble dot.
  always_comb begin
    lo_a_c = PW'($signed(a[3:0]));
    lo_w_c = PW'($signed(w[3:0]));
    hi_a_c = PW'($signed(a[7:4]));
    hi_w_c = PW'($signed(w[7:4]));
    prod_c = PW'($signed(a)) * PW'($signed(w));
    if (sel == MODE_SIMD4) begin
      prod_c = (lo_a_c * lo_w_c) + (hi_a_c * hi_w_c);
    end
  end

  always_comb begin
    sum_c     = SAT_W'(acc) + SAT_W'(s1_prod);
    sat_c     = sat_acc(sum_c, ACCW);
    new_ovf_c = (sat_c != sum_c);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_prod  <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
      out_byte <= '0;
      out_ovf  <= 1'b0;
    end else begin
      if (cap_en) s1_prod <= prod_c;
      if (clr) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (acc_en) begin
        acc <= ACCW'(sat_c);
        ovf <= ovf | new_ovf_c;
      end else if (close_en) begin
        // The closing sum is clamped to the accumulator range before requantising.
        acc      <= '0;
        ovf      <= 1'b0;
        out_byte <= DW'(sat_dw(sat_c >>> shift));
        out_ovf  <= ovf | new_ovf_c;
      end
    end
  end

endmodule

// File: rtl/mac_lane_array.sv
// LANES-wide signed MAC array with broadcast weight, per-vector requantise,
// and valid/ready flow control with a synchronous hold.
module mac_lane_array
  import mac_pkg::*;
#(
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned ACCW  = DEF_ACCW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  hold,
  input  logic                  sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [LANES*DW-1:0]   in_data,
  input  logic [DW-1:0]         w,
  input  logic [SHW-1:0]        shift,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   out_data,
  output logic [LANES-1:0]      out_ovf
);

  logic           s1_v;
  logic           s1_last;
  logic [SHW-1:0] s1_shift;
  logic           stall_c;
  logic           in_fire_c;
  logic           cap_en_c;
  logic           acc_en_c;
  logic           close_en_c;

  // A closing beat in S1 may not overwrite a result the consumer has not taken.
  always_comb begin
    stall_c    = hold | (out_valid & ~out_ready & s1_v & s1_last);
    in_ready   = ~stall_c;
    in_fire_c  = in_valid & ~stall_c;
    cap_en_c   = in_fire_c & ~clr;
    acc_en_c   = s1_v & ~s1_last & ~stall_c & ~clr;
    close_en_c = s1_v & s1_last & ~stall_c & ~clr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v     <= 1'b0;
      s1_last  <= 1'b0;
      s1_shift <= '0;
    end else if (clr) begin
      s1_v <= 1'b0;
    end else if (!stall_c) begin
      s1_v <= in_fire_c;
      if (in_fire_c) begin
        s1_last  <= in_last;
        s1_shift <= shift;
      end
    end
  end

  // Output handshake runs regardless of hold; a same-edge close reloads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
    end else if (close_en_c) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    mac_lane #(
      .DW   (DW),
      .ACCW (ACCW)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .cap_en   (cap_en_c),
      .acc_en   (acc_en_c),
      .close_en (close_en_c),
      .sel      (sel),
      .a        (in_data[DW*i +: DW]),
      .w        (w),
      .shift    (s1_shift),
      .out_byte (out_data[DW*i +: DW]),
      .out_ovf  (out_ovf[i])
    );
  end

endmodule

// File: tb/tb_mac_lane_array.sv
// Directed plus randomized checks of mac_lane_array against a per-vector
// arithmetic reference model.
module tb_mac_lane_array;

  localparam int unsigned LANES = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned ACCW  = 17;
  localparam longint ACC_MAX = (longint'(1) <<< (ACCW - 1)) - 1;
  localparam longint ACC_MIN = -ACC_MAX - 1;

  logic                clk = 1'b0;
  logic                rst, clr, hold, sel, in_valid, in_last, out_ready;
  logic                in_ready, out_valid;
  logic [LANES*DW-1:0] in_data, out_data;
  logic [DW-1:0]       w;
  logic [4:0]          shift;
  logic [LANES-1:0]    out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  longint              m_acc[LANES];
  bit                  m_ovf[LANES];
  logic [LANES*DW-1:0] exp_vec;
  logic [LANES-1:0]    exp_ovfv;
  logic [LANES*DW-1:0] saved_vec;

  mac_lane_array #(.LANES(LANES), .DW(DW), .ACCW(ACCW)) dut (
    .clk(clk), .rst(rst), .clr(clr), .hold(hold), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_data(in_data), .w(w), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint nib(input logic [3:0] v);
    return v[3] ? longint'(v) - 16 : longint'(v);
  endfunction

  function automatic longint prod(input bit s, input logic [7:0] a, input logic [7:0] wv);
    if (!s) return longint'($signed(a)) * longint'($signed(wv));
    return nib(a[3:0]) * nib(wv[3:0]) + nib(a[7:4]) * nib(wv[7:4]);
  endfunction

  function automatic longint clamp(input longint x, input longint lo, input longint hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  function automatic logic [LANES*DW-1:0] rep(input logic [7:0] v);
    return {LANES{v}};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) begin
      m_acc[i] = 0;
      m_ovf[i] = 0;
    end
  endtask

  task automatic model_beat(input bit s, input logic [LANES*DW-1:0] d, input logic [7:0] wv,
                            input bit last, input logic [4:0] sh);
    for (int i = 0; i < LANES; i++) begin
      longint sum;
      longint c;
      sum = m_acc[i] + prod(s, d[DW*i +: DW], wv);
      c   = clamp(sum, ACC_MIN, ACC_MAX);
      if (c != sum) m_ovf[i] = 1;
      if (last) begin
        exp_vec[DW*i +: DW] = DW'(clamp(c >>> sh, -128, 127));
        exp_ovfv[i] = m_ovf[i];
        m_acc[i] = 0;
        m_ovf[i] = 0;
      end else begin
        m_acc[i] = c;
      end
    end
  endtask

  // Present one beat, wait (bounded) for acceptance, then update the model.
  task automatic beat(input bit s, input logic [LANES*DW-1:0] d, input logic [7:0] wv,
                      input bit last, input logic [4:0] sh);
    int guard = 0;
    sel = s; in_data = d; w = wv; in_last = last; shift = sh; in_valid = 1'b1;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (in_ready !== 1'b1) check("in_ready_timeout", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    model_beat(s, d, wv, last, sh);
  endtask

  task automatic expect_result(input string tag);
    int guard = 0;
    while (out_valid !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'(1));
    check({tag, "_data"}, 64'(out_data), 64'(exp_vec));
    check({tag, "_ovf"}, 64'(out_ovf), 64'(exp_ovfv));
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("accept_clears", 64'(out_valid), 64'(0));
  endtask

  initial begin
    rst = 1'b0; clr = 1'b0; hold = 1'b1; sel = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0; in_data = '0; w = '0; shift = '0;
    exp_vec = '0; exp_ovfv = '0; saved_vec = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_ovf", 64'(out_ovf), 64'(0));
    check("rst_in_ready_hold", 64'(in_ready), 64'(0));
    hold = 1'b0; #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Basic int8 dot with latency check
    beat(1'b0, rep(8'd2), 8'd3, 1'b0, 5'd0);
    beat(1'b0, rep(8'hff), 8'd3, 1'b0, 5'd0);
    beat(1'b0, rep(8'd5), 8'd3, 1'b1, 5'd0);
    check("int8_latency_early", 64'(out_valid), 64'(0));
    @(posedge clk); #1;
    check("int8_latency_valid", 64'(out_valid), 64'(1));
    check("int8_lane0_18", 64'(out_data[7:0]), 64'(18));
    expect_result("int8");
    accept();

    // SIMD nibble dot
    beat(1'b1, rep(8'h2f), 8'h33, 1'b1, 5'd0);
    expect_result("simd");
    check("simd_lane3", 64'(out_data[31:24]), 64'(3));
    accept();

    // Requantise then negative saturation
    for (int b = 0; b < 4; b++) beat(1'b0, rep(8'd127), 8'd127, b == 3, 5'd2);
    expect_result("requant");
    check("requant_127", 64'(out_data[7:0]), 64'(8'h7f));
    accept();
    beat(1'b0, rep(8'h80), 8'd127, 1'b1, 5'd0);
    expect_result("negsat");
    check("negsat_m128", 64'(out_data[15:8]), 64'(8'h80));
    accept();

    // Accumulator overflow, then a clean vector
    for (int b = 0; b < 5; b++) beat(1'b0, rep(8'd127), 8'd127, b == 4, 5'd0);
    expect_result("accovf");
    check("accovf_flag", 64'(out_ovf), 64'(4'hf));
    check("accovf_127", 64'(out_data[23:16]), 64'(8'h7f));
    accept();
    beat(1'b0, rep(8'd1), 8'd1, 1'b1, 5'd0);
    expect_result("postovf");
    check("postovf_flag", 64'(out_ovf), 64'(0));
    accept();

    // Randomized vectors with per-beat mode
    for (int v = 0; v < 24; v++) begin
      int len;
      logic [4:0] sh;
      len = 1 + int'($urandom_range(0, 4));
      sh  = 5'($urandom_range(0, 9));
      for (int b = 0; b < len; b++)
        beat(1'($urandom), (LANES*DW)'($urandom), 8'($urandom), b == len - 1, sh);
      expect_result("rand");
      accept();
    end

    // Backpressure: second closing beat waits, then loads on the accepting edge
    beat(1'b0, (LANES*DW)'($urandom), 8'($urandom), 1'b1, 5'd1);
    expect_result("bp_first");
    saved_vec = exp_vec;
    beat(1'b1, (LANES*DW)'($urandom), 8'($urandom), 1'b0, 5'd0);
    beat(1'b0, (LANES*DW)'($urandom), 8'($urandom), 1'b1, 5'd0);
    check("bp_in_ready_low", 64'(in_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    check("bp_first_stable", 64'(out_data), 64'(saved_vec));
    check("bp_in_ready_still_low", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_second_valid", 64'(out_valid), 64'(1));
    check("bp_second_data", 64'(out_data), 64'(exp_vec));
    accept();

    // Hold mid-vector leaves the sum unchanged
    beat(1'b0, (LANES*DW)'($urandom), 8'($urandom), 1'b0, 5'd0);
    hold = 1'b1; in_valid = 1'b1; in_data = (LANES*DW)'($urandom); w = 8'($urandom);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("hold_in_ready", 64'(in_ready), 64'(0));
      @(posedge clk); #1;
    end
    hold = 1'b0; in_valid = 1'b0;
    beat(1'b1, (LANES*DW)'($urandom), 8'($urandom), 1'b0, 5'd0);
    beat(1'b0, (LANES*DW)'($urandom), 8'($urandom), 1'b1, 5'd1);
    expect_result("hold");

    // clr discards partial sums and keeps the pending result
    saved_vec = exp_vec;
    beat(1'b0, rep(8'd100), 8'd100, 1'b0, 5'd0);
    beat(1'b0, rep(8'd100), 8'd100, 1'b0, 5'd0);
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_reset();
    check("clr_keeps_valid", 64'(out_valid), 64'(1));
    check("clr_keeps_data", 64'(out_data), 64'(saved_vec));
    accept();
    beat(1'b0, rep(8'd4), 8'd5, 1'b1, 5'd0);
    expect_result("clr_next");
    check("clr_next_20", 64'(out_data[7:0]), 64'(20));

    // Asynchronous reset mid-vector with a result pending
    beat(1'b0, (LANES*DW)'($urandom), 8'($urandom), 1'b0, 5'd0);
    beat(1'b0, (LANES*DW)'($urandom), 8'($urandom), 1'b0, 5'd0);
    #2 rst = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'(0));
    check("arst_out_data", 64'(out_data), 64'(0));
    check("arst_out_ovf", 64'(out_ovf), 64'(0));
    check("arst_in_ready", 64'(in_ready), 64'(1));
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    beat(1'b0, rep(8'd7), 8'hfe, 1'b1, 5'd0);
    expect_result("post_rst");
    check("post_rst_m14", 64'(out_data[7:0]), 64'(8'hf2));
    accept();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_lane_array.md
# mac_lane_array

Parametrised next-generation MAC array for the accelerator datapath. It has LANES independent signed multiply-accumulate lanes. Each lane takes one DW-bit activation per beat; one DW-bit weight per beat is broadcast to all lanes. Lanes accumulate across a vector delimited by `in_last`, then requantise (shift and saturate) to DW bits. Flow control is valid/ready with a synchronous `hold` input; the clock is never gated. The array sits between the activation buffer and the CORDIC activation engine.

## Interface
- `LANES`, 16: number of parallel MAC lanes (1..1024).
- `DW`, 8: data/weight/result width; fixed at 8 in this generation (SIMD mode requires 8).
- `ACCW`, 24: per-lane accumulator width (≥ 2*DW+1).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `clr` input 1: synchronous flush of accumulators, the S1 stage and overflow flags.
- `hold` input 1: synchronous freeze of all state; replaces clock gating.
- `sel` input 1: per-beat mode; 0 = 8x8 signed, 1 = dual 4x4 signed SIMD dot.
- `in_valid` input 1: beat valid.
- `in_ready` output 1: array can accept a beat.
- `in_last` input 1: final beat of the current vector.
- `in_data` input LANES*DW: lane i activation at `[DW*i +: DW]`.
- `w` input DW: broadcast weight.
- `shift` input 5: requantisation right-shift, sampled with the last beat.
- `out_valid` output 1: result vector available.
- `out_ready` input 1: consumer accepts the result.
- `out_data` output LANES*DW: saturated results, lane i at `[DW*i +: DW]`.
- `out_ovf` output LANES: lane i accumulator saturated during this vector.

## Operation
- Product, mode 0: `a*w` signed, 16 bits.
- Product, mode 1: `a[3:0]*w[3:0] + a[7:4]*w[7:4]`, all nibbles signed; range −112..128.
- Products are sign-extended to ACCW.
- `in_fire = in_valid & in_ready`.
- **S1 register:** on `in_fire`, captures LANES products, `last` and `shift`, and sets `s1_v`; otherwise `s1_v` clears.
- **Accumulate:** when `s1_v` and not last, `acc <= sat_ACCW(acc + prod)`. If saturation occurs, set the lane's sticky `ovf`.
- **Close vector:** when `s1_v & last`:
  - `out_data[i] <= sat_DW((acc[i] + prod[i]) >>> shift)`; the shift is arithmetic and truncates toward −inf.
  - `out_ovf <= ovf | new overflow`.
  - `acc <= 0`, `ovf <= 0`, `out_valid <= 1`.
- `sat_DW` clamps to −128..127. `sat_ACCW` clamps to −2^(ACCW−1)..2^(ACCW−1)−1.
- Output handshake:
  - `out_valid & out_ready` clears `out_valid`, unless a new close occurs on the same edge, in which case the new result loads and `out_valid` stays 1.
  - `out_data` holds its value while `out_valid` is 1.
- `in_ready = ~hold & ~(out_valid & ~out_ready & pend)`, where `pend` means `s1_v & s1_last`. A closing beat therefore cannot overwrite an unaccepted result.
- Stall when `stall = hold | (out_valid & ~out_ready & s1_v & s1_last)`. On a stall, S1, the accumulators and `ovf` keep their values.
- `hold` does not block the output handshake.
- `clr` has priority over `hold` and `in_fire`. On the next edge it sets `s1_v=0`, `acc=0` and `ovf=0`. The output register and `out_valid` are unaffected.
- A vector of one beat (`in_last` on the first beat) is legal.
- `sel` may change on any beat; each beat uses its own `sel`.

## Timing
- Reset values: `s1_v=0`, `acc=0`, `ovf=0`, `out_valid=0`, `out_data=0`, `out_ovf=0`. The reset-state value of `in_ready` is `~hold`.
- Latency: a last beat fired on edge t produces `out_valid=1` after edge t+1, i.e. 2 cycles from its presentation.
- Throughput: 1 beat/cycle while the output is not backpressured.
- Reset asserted mid-vector discards all partial sums immediately, asynchronously.
- `in_ready` is combinational from `hold`, `out_valid`, `out_ready` and S1 state. It has no path from `in_valid`.

## Structure
- Shared package `mac_pkg`:
  - mode constants `MODE_INT8=1'b0`, `MODE_SIMD4=1'b1`;
  - saturation functions `sat_acc` and `sat_dw`;
  - default widths.
- Sub-module `mac_lane` holds one lane's product logic, S1 data, accumulator, `ovf` and output byte.
- The top generates LANES `mac_lane` instances and owns the shared S1 valid/last/shift registers and the handshake.

## Test plan
- **Basic int8 dot:** LANES=4, sel=0, w=3 for 3 beats with a=2,−1,5 and last on the 3rd, shift=0 → `out_data` lane=18, `out_valid` 2 cycles after the last beat, `out_ovf=0`.
- **SIMD mode:** sel=1, a=8'h2F (hi=2, lo=−1), w=8'h33 (hi=3, lo=3), single beat, shift=0 → 3 (6 + −3).
- **Requantise/saturate:** a=127, w=127 for 4 beats, shift=2 → 16129*4>>2 = 16129 → 127. Then a=−128, w=127, shift=0 → −128.
- **Accumulator overflow:** ACCW=17, a=127, w=127 for 5 beats → accumulator clamps at 65535, `out_ovf=1`, output 127. The next vector reports `out_ovf=0`.
- **Backpressure/hold:**
  - `out_ready=0` with a second vector's last beat in S1 → `in_ready=0`, first result stable.
  - Raising `out_ready` transfers the first result and loads the second on the same edge.
  - `hold=1` for 3 cycles mid-vector → sum unchanged versus a no-hold run.
- **clr/reset:**
  - `clr` after 2 of 3 beats → the next vector's result excludes the discarded beats and a pending `out_valid` is kept.
  - `rst` low mid-vector → all outputs 0 immediately.
